// File: rtl/pwm_pkg.sv
// Shared PWM helpers: counter width derivation and the clamp / step-toward-target math.
// Also used by the servo engine so both ramp identically.
package pwm_pkg;

  function automatic int pwm_cnt_w(input int period);
    return $clog2(period + 1);
  endfunction

  function automatic int unsigned pwm_clamp(input int unsigned v, input int unsigned lim);
    return (v > lim) ? lim : v;
  endfunction

  // Widened arithmetic keeps duty+step from wrapping and duty-step from underflowing.
  function automatic int unsigned pwm_step_toward(input int unsigned duty,
                                                  input int unsigned target,
                                                  input int unsigned step);
    if (step == 0)
      return target;
    if (duty < target)
      return pwm_clamp(duty + step, target);
    if (duty > target)
      return ((duty - target) > step) ? (duty - step) : target;
    return duty;
  endfunction

endpackage

// File: rtl/pwm_ramp_channel.sv
// One PWM channel: target/step config, wrap-time duty ramp and registered compare output.
// Output is one cycle behind the shared counter; config writes are always accepted.
module pwm_ramp_channel
  import pwm_pkg::*;
#(
  parameter int PERIOD = 1250,
  parameter int CNT_W  = pwm_cnt_w(PERIOD)
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_enable,
  input  logic             i_wrap,
  input  logic             i_wr,
  input  logic [CNT_W-1:0] i_cnt,
  input  logic [CNT_W-1:0] i_target,
  input  logic [CNT_W-1:0] i_step,
  output logic             o_pwm,
  output logic             o_done
);

  logic [CNT_W-1:0] r_target;
  logic [CNT_W-1:0] r_step;
  logic [CNT_W-1:0] r_duty;
  logic             r_pwm;
  logic [CNT_W-1:0] w_target_clamped;
  logic [CNT_W-1:0] w_duty_next;

  assign w_target_clamped = CNT_W'(pwm_clamp(32'(i_target), PERIOD));
  assign w_duty_next      = CNT_W'(pwm_step_toward(32'(r_duty), 32'(r_target), 32'(r_step)));

  // Duty only moves on a wrap, so a period is never cut short by a mid-period write.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_target <= '0;
      r_step   <= '0;
      r_duty   <= '0;
      r_pwm    <= 1'b0;
    end else begin
      if (i_wr) begin
        r_target <= w_target_clamped;
        r_step   <= i_step;
      end
      if (i_wrap)
        r_duty <= w_duty_next;
      r_pwm <= i_enable && (i_cnt < r_duty);
    end
  end

  assign o_pwm  = r_pwm;
  assign o_done = (r_duty == r_target);

endmodule

// File: rtl/pwm_ramp_multi.sv
// N-channel ramping PWM engine on one shared free-running period counter.
// pwm_out lags the counter by one cycle; cfg writes are accepted every cycle (no backpressure).
module pwm_ramp_multi
  import pwm_pkg::*;
#(
  parameter int N_CH   = 3,
  parameter int PERIOD = 1250,
  parameter int CNT_W  = pwm_cnt_w(PERIOD),
  parameter int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             cfg_wr,
  input  logic [CH_W-1:0]  cfg_ch,
  input  logic [CNT_W-1:0] cfg_target,
  input  logic [CNT_W-1:0] cfg_step,
  output logic [N_CH-1:0]  pwm_out,
  output logic             period_tick,
  output logic [N_CH-1:0]  ramp_done
);

  logic [CNT_W-1:0] r_cnt;
  logic             r_tick;
  logic             w_wrap;
  logic [N_CH-1:0]  w_wr;

  assign w_wrap = enable && (r_cnt == CNT_W'(PERIOD - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_tick <= w_wrap;
      if (!enable || w_wrap)
        r_cnt <= '0;
      else
        r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign period_tick = r_tick;

  // Out-of-range channel indices match no instance and are dropped.
  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    assign w_wr[g] = cfg_wr && (32'(cfg_ch) == g);

    pwm_ramp_channel #(
      .PERIOD (PERIOD),
      .CNT_W  (CNT_W)
    ) u_ch (
      .i_clk    (clk),
      .i_reset  (reset),
      .i_enable (enable),
      .i_wrap   (w_wrap),
      .i_wr     (w_wr[g]),
      .i_cnt    (r_cnt),
      .i_target (cfg_target),
      .i_step   (cfg_step),
      .o_pwm    (pwm_out[g]),
      .o_done   (ramp_done[g])
    );
  end

endmodule
